// File: rtl/life_manager_pkg.sv
// life_pkg: shared state encoding and datapath widths for the life manager
package life_pkg;
  typedef enum logic [1:0] {TITLE, PLAY, INVULN, OVER} life_state_t;
  localparam int SCORE_W = 16;
  localparam int TIMER_W = 12;
  localparam int LIVES_W = 3;
endpackage

// File: rtl/life_manager_btn_edge.sv
// btn_edge: two-flop synchroniser for the raw start button plus rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);
  logic [2:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[1:0], i_btn};
  assign o_rise = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/life_manager.sv
// life_manager: lives/invulnerability/game-over FSM with survival score
// Optional HISCORE_EN keeps the best score since reset; otherwise hiscore is tied to 0.
module life_manager
  import life_pkg::*;
#(
  parameter int LIVES     = 3,
  parameter int IFRAMES   = 120,
  parameter int OVER_HOLD = 240
) (
  input  logic               GameClock,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic               hurt,
  output logic               start,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               blink,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);
  life_state_t        r_state, w_next;
  logic [TIMER_W-1:0] r_timer, w_timer;
  logic [LIVES_W-1:0] w_lives;
  logic [SCORE_W-1:0] w_score, w_inc;
  logic               w_rise;

  btn_edge u_btn (.clk(GameClock), .rst_n(reset_n), .i_btn(start_btn), .o_rise(w_rise));

  assign w_inc = (score == '1) ? score : score + 1'b1;

  always_comb begin
    w_next  = r_state;
    w_timer = r_timer;
    w_lives = lives;
    w_score = score;
    unique case (r_state)
      TITLE: if (w_rise) begin
        w_next  = PLAY;
        w_lives = LIVES_W'(LIVES);
        w_score = '0;
      end
      PLAY: begin
        w_score = w_inc;
        if (hurt && lives > 1) begin
          w_next  = INVULN;
          w_lives = lives - 1'b1;
          w_timer = TIMER_W'(IFRAMES - 1);
        end else if (hurt) begin
          w_next  = OVER;
          w_lives = '0;
          w_timer = TIMER_W'(OVER_HOLD - 1);
          w_score = score;
        end
      end
      INVULN: begin
        w_score = w_inc;
        w_next  = (r_timer == '0) ? PLAY : INVULN;
        w_timer = (r_timer == '0) ? r_timer : r_timer - 1'b1;
      end
      OVER: begin
        w_next  = (r_timer == '0) ? TITLE : OVER;
        w_timer = (r_timer == '0) ? r_timer : r_timer - 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge GameClock or negedge reset_n)
    if (!reset_n) begin
      r_state   <= TITLE;
      r_timer   <= '0;
      lives     <= '0;
      score     <= '0;
      start     <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      lives     <= w_lives;
      score     <= w_score;
      start     <= (w_next == PLAY) || (w_next == INVULN);
      invuln    <= w_next == INVULN;
      blink     <= (w_next == INVULN) && w_timer[3];
      game_over <= w_next == OVER;
    end

`ifdef HISCORE_EN
  always_ff @(posedge GameClock or negedge reset_n)
    if (!reset_n) hiscore <= '0;
    else if (r_state != OVER && w_next == OVER && score > hiscore) hiscore <= score;
`else
  assign hiscore = '0;
`endif
endmodule
